// File: rtl/mul_arb_ctrl.sv
// Two-requester round-robin front end for a shared sequential unsigned multiplier.
// It applies signed fix-up around the core, routes the product to the owner, and turns a missing done into an error.
module mul_arb_ctrl #(
  parameter int W       = 64,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [W-1:0]     req0_a_i,
  input  logic [W-1:0]     req0_b_i,
  input  logic             req0_signed_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [W-1:0]     req1_a_i,
  input  logic [W-1:0]     req1_b_i,
  input  logic             req1_signed_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [2*W-1:0]   rsp0_y_o,
  output logic [TAG_W-1:0] rsp0_tag_o,
  output logic             rsp0_err_o,

  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [2*W-1:0]   rsp1_y_o,
  output logic [TAG_W-1:0] rsp1_tag_o,
  output logic             rsp1_err_o,

  output logic             mul_start_o,
  output logic [W-1:0]     mul_a_o,
  output logic [W-1:0]     mul_b_o,
  input  logic             mul_done_i,
  input  logic [2*W-1:0]   mul_y_i,

  output logic             busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q;
  logic [W-1:0]     mul_a_q;
  logic [W-1:0]     mul_b_q;
  logic             mul_start_q;
  logic [TW-1:0]    timer_q;
  logic [2*W-1:0]   y_q;
  logic             err_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;

  logic             grant_sel;
  logic             accept;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             sel_signed;
  logic [TAG_W-1:0] sel_tag;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic [2*W-1:0]   y_d;
  logic             rsp_ready;

  always_comb begin
    // Lone requester wins outright; on contention the one not served last time wins.
    grant_sel    = req1_valid_i & ~(req0_valid_i & last_grant_q);
    req0_ready_o = (state_q == S_IDLE) & req0_valid_i & ~grant_sel;
    req1_ready_o = (state_q == S_IDLE) & req1_valid_i & grant_sel;
    accept       = req0_ready_o | req1_ready_o;

    sel_a      = grant_sel ? req1_a_i      : req0_a_i;
    sel_b      = grant_sel ? req1_b_i      : req0_b_i;
    sel_signed = grant_sel ? req1_signed_i : req0_signed_i;
    sel_tag    = grant_sel ? req1_tag_i    : req0_tag_i;

    // Negating the most negative value wraps to 2^(W-1), which is exactly its magnitude.
    a_mag = (sel_signed & sel_a[W-1]) ? -sel_a : sel_a;
    b_mag = (sel_signed & sel_b[W-1]) ? -sel_b : sel_b;

    y_d       = neg_q ? -mul_y_i : mul_y_i;
    rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      timer_q      <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q     <= grant_sel;
            tag_q       <= sel_tag;
            neg_q       <= sel_signed & (sel_a[W-1] ^ sel_b[W-1]);
            mul_a_q     <= a_mag;
            mul_b_q     <= b_mag;
            mul_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          // A done arriving on the last allowed cycle still counts as success.
          if (mul_done_i) begin
            y_q          <= y_d;
            err_q        <= 1'b0;
            rsp0_valid_q <= ~owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            y_q          <= '0;
            err_q        <= 1'b1;
            rsp0_valid_q <= ~owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_start_o  = mul_start_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign busy_o       = (state_q != S_IDLE);

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_y_o     = rsp0_valid_q ? y_q   : '0;
  assign rsp0_tag_o   = rsp0_valid_q ? tag_q : '0;
  assign rsp0_err_o   = rsp0_valid_q & err_q;

  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_y_o     = rsp1_valid_q ? y_q   : '0;
  assign rsp1_tag_o   = rsp1_valid_q ? tag_q : '0;
  assign rsp1_err_o   = rsp1_valid_q & err_q;

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Directed bench for mul_arb_ctrl: the multiplier is played by the stimulus, which
// raises mul_done a chosen number of cycles after the start pulse with a hand-computed product.
module tb_mul_arb_ctrl;
  localparam int W       = 64;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_signed;
  logic [W-1:0]     req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_signed;
  logic [W-1:0]     req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_err;
  logic [2*W-1:0]   rsp0_y;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid, rsp1_ready, rsp1_err;
  logic [2*W-1:0]   rsp1_y;
  logic [TAG_W-1:0] rsp1_tag;
  logic             mul_start, mul_done, busy;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_y;

  int tests = 0;
  int fails = 0;

  mul_arb_ctrl #(.W(W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req0_signed_i(req0_signed), .req0_tag_i(req0_tag),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .req1_signed_i(req1_signed), .req1_tag_i(req1_tag),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_y_o(rsp0_y), .rsp0_tag_o(rsp0_tag),
    .rsp0_err_o(rsp0_err),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_y_o(rsp1_y), .rsp1_tag_o(rsp1_tag),
    .rsp1_err_o(rsp1_err),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_done_i(mul_done), .mul_y_i(mul_y),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered on a negedge with the requester's valid already driven; returns on the start-pulse negedge.
  task automatic issue(input int n);
    #1;
    chk("req_ready", 128'(n != 0 ? req1_ready : req0_ready), 1);
    chk("other_ready", 128'(n != 0 ? req0_ready : req1_ready), 0);
    @(negedge clk);
    chk("mul_start", 128'(mul_start), 1);
  endtask

  task automatic run_done(input int lat, input logic [127:0] y);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) chk("start_pulse_len", 128'(mul_start), 0);
    end
    chk("rsp_early", 128'({rsp0_valid, rsp1_valid}), 0);
    mul_done = 1'b1;
    mul_y    = y;
    @(negedge clk);
    mul_done = 1'b0;
    mul_y    = '0;
  endtask

  task automatic chk_rsp(input int n, input logic [127:0] y, input logic [3:0] tag, input logic err);
    chk("rsp_valid", 128'(n != 0 ? rsp1_valid : rsp0_valid), 1);
    chk("rsp_other_valid", 128'(n != 0 ? rsp0_valid : rsp1_valid), 0);
    chk("rsp_y", n != 0 ? rsp1_y : rsp0_y, y);
    chk("rsp_tag", 128'(n != 0 ? rsp1_tag : rsp0_tag), 128'(tag));
    chk("rsp_err", 128'(n != 0 ? rsp1_err : rsp0_err), 128'(err));
  endtask

  task automatic rel(input int n);
    if (n != 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("idle_after_rsp", 128'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_signed = 0; req0_tag = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_signed = 0; req1_tag = '0;
    rsp0_ready = 0; rsp1_ready = 0; mul_done = 0; mul_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_start", 128'(mul_start), 0);
    chk("rst_mul_a", 128'(mul_a), 0);
    chk("rst_rsp_valid", 128'({rsp0_valid, rsp1_valid}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 3*5 on req0, model latency 128
    req0_valid = 1; req0_a = 64'd3; req0_b = 64'd5; req0_signed = 0; req0_tag = 4'd2;
    issue(0);
    req0_valid = 0;
    chk("u_mul_a", 128'(mul_a), 3);
    chk("u_mul_b", 128'(mul_b), 5);
    chk("u_busy", 128'(busy), 1);
    run_done(128, 128'd15);
    chk_rsp(0, 128'd15, 4'd2, 1'b0);
    rel(0);

    // Signed -3*7 on req1
    req1_valid = 1; req1_a = 64'hFFFF_FFFF_FFFF_FFFD; req1_b = 64'd7; req1_signed = 1; req1_tag = 4'd5;
    issue(1);
    req1_valid = 0;
    req1_a = 64'd99;
    chk("s_mul_a", 128'(mul_a), 3);
    chk("s_mul_b", 128'(mul_b), 7);
    run_done(3, 128'd21);
    chk_rsp(1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 4'd5, 1'b0);
    rel(1);

    // Most negative times -1
    req1_valid = 1; req1_a = 64'h8000_0000_0000_0000; req1_b = 64'hFFFF_FFFF_FFFF_FFFF; req1_tag = 4'd6;
    issue(1);
    req1_valid = 0;
    chk("min_mul_a", 128'(mul_a), 128'h8000_0000_0000_0000);
    chk("min_mul_b", 128'(mul_b), 1);
    run_done(3, 128'h8000_0000_0000_0000);
    chk_rsp(1, 128'h8000_0000_0000_0000, 4'd6, 1'b0);
    rel(1);

    // Contention: both valid throughout, grants alternate starting with req0
    req0_valid = 1; req0_a = 64'd2; req0_b = 64'd3; req0_signed = 0; req0_tag = 4'd8;
    req1_valid = 1; req1_a = 64'd4; req1_b = 64'd5; req1_signed = 0; req1_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      issue(i % 2);
      chk("rr_mul_a", 128'(mul_a), (i % 2 != 0) ? 128'd4 : 128'd2);
      run_done(3, (i % 2 != 0) ? 128'd20 : 128'd6);
      chk_rsp(i % 2, (i % 2 != 0) ? 128'd20 : 128'd6, (i % 2 != 0) ? 4'd9 : 4'd8, 1'b0);
      rel(i % 2);
    end
    req0_valid = 0; req1_valid = 0;

    // Watchdog: no done at all
    req0_valid = 1; req0_a = 64'd1; req0_b = 64'd1; req0_tag = 4'd3;
    issue(0);
    req0_valid = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT) begin
        chk("to_not_yet", 128'(rsp0_valid), 0);
        chk("to_busy", 128'(busy), 1);
      end
    end
    @(negedge clk);
    chk_rsp(0, 128'd0, 4'd3, 1'b1);
    rel(0);

    // Done on the final timer cycle wins over the watchdog
    req0_valid = 1; req0_a = 64'd6; req0_b = 64'd7; req0_tag = 4'd4;
    issue(0);
    req0_valid = 0;
    run_done(TIMEOUT, 128'd42);
    chk_rsp(0, 128'd42, 4'd4, 1'b0);
    rel(0);

    // Response stall while req1 waits
    req0_valid = 1; req0_a = 64'd9; req0_b = 64'd9; req0_tag = 4'd7;
    issue(0);
    req0_valid = 0;
    run_done(3, 128'd81);
    req1_valid = 1; req1_a = 64'd2; req1_b = 64'd2; req1_signed = 0; req1_tag = 4'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 128'(rsp0_valid), 1);
      chk("stall_y", rsp0_y, 128'd81);
      chk("stall_tag", 128'(rsp0_tag), 7);
      chk("stall_req1_ready", 128'(req1_ready), 0);
    end
    @(negedge clk);
    rsp0_ready = 1;
    #1;
    chk("exit_no_accept", 128'(req1_ready), 0);
    @(negedge clk);
    rsp0_ready = 0;
    issue(1);
    req1_valid = 0;
    run_done(3, 128'd4);
    chk_rsp(1, 128'd4, 4'd1, 1'b0);
    rel(1);

    // Reset in WAIT, then a stray done, then a normal transaction
    req0_valid = 1; req0_a = 64'd5; req0_b = 64'd5; req0_tag = 4'd10;
    issue(0);
    req0_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 128'(busy), 0);
    chk("mid_rst_mul_a", 128'(mul_a), 0);
    chk("mid_rst_mul_b", 128'(mul_b), 0);
    chk("mid_rst_rsp", 128'({rsp0_valid, rsp1_valid}), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mul_done = 1; mul_y = 128'd25;
    @(negedge clk);
    mul_done = 0; mul_y = '0;
    @(negedge clk);
    chk("stray_done_busy", 128'(busy), 0);
    chk("stray_done_rsp", 128'(rsp0_valid), 0);
    req1_valid = 1; req1_a = 64'd10; req1_b = 64'd10; req1_signed = 0; req1_tag = 4'd11;
    issue(1);
    req1_valid = 0;
    run_done(3, 128'd100);
    chk_rsp(1, 128'd100, 4'd11, 1'b0);
    rel(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_arb_ctrl.md
Name: mul_arb_ctrl

Overview:
Controller and arbiter that shares one sequential 64-bit multiplier between two requesters, such as the integer pipe and a divide/MAC helper. It accepts operand requests, arbitrates round-robin, and sequences the multiplier through a start/done handshake. It applies signed-to-unsigned fix-up around the unsigned core and routes the full product back to the owning requester. A watchdog converts a missing done into an error response.

Parameters:
W, 64, operand width; product width is 2*W
TAG_W, 4, requester tag width, returned unchanged
TIMEOUT, 200, max cycles in WAIT before error (must exceed multiplier latency, 128+)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
reqN_valid  in  1  request valid, N=0,1
reqN_ready  out  1  request accepted this cycle
reqN_a, reqN_b  in  W each  operands
reqN_signed  in  1  1 = treat a, b as two's complement
reqN_tag  in  TAG_W  opaque tag
rspN_valid  out  1  response valid
rspN_ready  in  1  response consumed
rspN_y  out  2*W  product
rspN_tag  out  TAG_W  tag of the request being answered
rspN_err  out  1  1 = watchdog timeout, rspN_y = 0
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a, mul_b  out  W each  unsigned magnitudes, stable from ISSUE until WAIT exits
mul_done  in  1  multiplier result-valid pulse
mul_y  in  2*W  unsigned product from the multiplier
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (Rst=0, async): state=IDLE, all outputs 0, timer=0, last_grant=1 (req0 wins first contention). Reset mid-operation abandons the transaction; no response is issued.
- One transaction outstanding at a time. States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - sel = the only valid requester; if both are valid, sel = !last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && sel==N. This is combinational from the valids; never both high.
  - On handshake, register owner, tag, neg = signed & (a[W-1]^b[W-1]), and magnitudes |a|, |b| (plain value if unsigned). Go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle, timer cleared; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - mul_done=1: y = neg ? (0 - mul_y) mod 2^(2W) : mul_y; err=0; go to RESP.
  - Otherwise, at timer==TIMEOUT-1: y=0, err=1, go to RESP.
  - mul_done on the timeout cycle: done wins, err=0.
- RESP:
  - rsp<owner>_valid=1 with y, tag, err held stable; the other rsp_valid stays 0.
  - On rsp_ready: last_grant=owner, go to IDLE. Stalls indefinitely while rsp_ready=0.
- mul_done outside WAIT is ignored.
- No request is accepted in the cycle RESP exits; the earliest next accept is the following cycle.
- Latency: accept at cycle t; mul_start at t+1; mul_done at t+1+L; rsp_valid at t+2+L.
- Width and sign rules:
  - The magnitude of -2^(W-1) is 2^(W-1), which fits in W unsigned bits.
  - Signed result is exact in 2*W bits; unsigned is zero-extended core output.
- Requester inputs are sampled only on the handshake cycle; changes afterward have no effect.

Test Plan:
- Reset then req0: a=3, b=5, unsigned, tag=2; model L=128 -> mul_start one cycle after accept; rsp0_y=15, tag=2, err=0; rsp1_valid stays 0.
- Signed req1: a=-3 (0xFF..FD), b=7 -> mul_a=3, mul_b=7; rsp1_y=-21 in 128 bits. Then a=-2^63, b=-1 -> mul_a=2^63, rsp1_y=2^63.
- Both valid every cycle for 4 transactions -> grants alternate 0,1,0,1; never both ready; each owner receives only its own tag.
- Model never asserts done -> rsp_valid with err=1, y=0 after TIMEOUT cycles in WAIT. Separately, done on exactly cycle TIMEOUT-1 -> err=0, correct y.
- rsp0_ready held low 10 cycles -> rsp0_valid, y and tag stable; req1 not accepted until after release.
- Rst pulsed low during WAIT -> immediate IDLE, all outputs 0; a later mul_done is ignored; the next request completes normally.
